// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths and a constant-safe clog2 for slave decoders.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 8;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_SEL_W  = 3;

    function automatic int unsigned bus_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_arbit.sv
// Registered round-robin arbiter with a per-owner hold limit; the bus always parks on an owner.
module bus_rr_arbit
    import bus_pkg::*;
#(
    parameter  int unsigned NUM_M    = 4,
    parameter  int unsigned MAX_HOLD = 4,
    localparam int unsigned OW       = bus_clog2(NUM_M),
    localparam int unsigned HW       = bus_clog2((MAX_HOLD > 1) ? MAX_HOLD : 2)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    output logic [NUM_M-1:0] m_grant,
    output logic [OW-1:0]    owner
);

    logic [NUM_M-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [OW-1:0]    next_owner;
    logic             others_req, at_limit, owner_req;

    // Search owner+1, owner+2, ... ; descending loop lets the nearest candidate win.
    always_comb begin
        logic [OW-1:0] cand;
        int            c;
        cand       = '0;
        c          = 0;
        next_owner = owner_q;
        for (int k = int'(NUM_M) - 1; k >= 1; k--) begin
            c    = (int'(owner_q) + k) % int'(NUM_M);
            cand = OW'(c);
            if (m_req[cand]) begin
                next_owner = cand;
            end
        end
    end

    assign others_req = |(m_req & ~grant_q);
    assign owner_req  = m_req[owner_q];
    assign at_limit   = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        owner_d = owner_q;
        hold_d  = '0;
        grant_d = '0;
        if (owner_req && !(at_limit && others_req)) begin
            // Keep owner; counter saturates at the limit when nobody else is waiting.
            if (MAX_HOLD != 0 && !at_limit) begin
                hold_d = hold_q + 1'b1;
            end else begin
                hold_d = hold_q;
            end
        end else if (|m_req) begin
            owner_d = next_owner;
        end
        grant_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= NUM_M'(1);
            owner_q <= '0;
            hold_q  <= '0;
        end else begin
            grant_q <= grant_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    assign m_grant = grant_q;
    assign owner   = owner_q;

endmodule

// File: rtl/bus_rr.sv
// Shared-bus interconnect: round-robin master arbitration, address decode, registered read return.
module bus_rr
    import bus_pkg::*;
#(
    parameter int unsigned NUM_M    = 4,
    parameter int unsigned NUM_S    = 4,
    parameter int unsigned ADDR_W   = BUS_ADDR_W,
    parameter int unsigned DATA_W   = BUS_DATA_W,
    parameter int unsigned SEL_W    = BUS_SEL_W,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_M-1:0]        m_req,
    input  logic [NUM_M-1:0]        m_wr,
    input  logic [NUM_M*ADDR_W-1:0] m_address,
    input  logic [NUM_M*DATA_W-1:0] m_dout,
    input  logic [NUM_S*DATA_W-1:0] s_dout,
    output logic [NUM_M-1:0]        m_grant,
    output logic [DATA_W-1:0]       m_din,
    output logic                    m_decerr,
    output logic [NUM_S-1:0]        s_sel,
    output logic [ADDR_W-1:0]       s_address,
    output logic                    s_wr,
    output logic [DATA_W-1:0]       s_din
);

    localparam int unsigned OW = bus_clog2(NUM_M);

    logic [OW-1:0]     owner;
    logic [ADDR_W-1:0] addr_arr  [NUM_M];
    logic [DATA_W-1:0] wdata_arr [NUM_M];
    logic [DATA_W-1:0] rdata_arr [NUM_S];
    logic [SEL_W-1:0]  idx;
    logic              dec_err;
    logic [SEL_W-1:0]  rd_idx_q;
    logic              rd_err_q;

    bus_rr_arbit #(
        .NUM_M   (NUM_M),
        .MAX_HOLD(MAX_HOLD)
    ) u_arbit (
        .clk    (clk),
        .reset_n(reset_n),
        .m_req  (m_req),
        .m_grant(m_grant),
        .owner  (owner)
    );

    for (genvar i = 0; i < NUM_M; i++) begin : g_mst
        assign addr_arr[i]  = m_address[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = m_dout[i*DATA_W +: DATA_W];
    end

    for (genvar j = 0; j < NUM_S; j++) begin : g_slv
        assign rdata_arr[j] = s_dout[j*DATA_W +: DATA_W];
    end

    // Owner's signals are forwarded even when it is not requesting.
    always_comb begin
        s_address = '0;
        s_wr      = 1'b0;
        s_din     = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (owner == OW'(i)) begin
                s_address = addr_arr[i];
                s_wr      = m_wr[i];
                s_din     = wdata_arr[i];
            end
        end
    end

    assign idx     = s_address[ADDR_W-1 -: SEL_W];
    assign dec_err = 32'(idx) >= NUM_S;

    always_comb begin
        s_sel = '0;
        for (int j = 0; j < int'(NUM_S); j++) begin
            s_sel[j] = (idx == SEL_W'(j));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx_q <= '0;
            rd_err_q <= 1'b0;
        end else begin
            rd_idx_q <= idx;
            rd_err_q <= dec_err;
        end
    end

    always_comb begin
        m_din = '0;
        for (int j = 0; j < int'(NUM_S); j++) begin
            if (!rd_err_q && rd_idx_q == SEL_W'(j)) begin
                m_din = rdata_arr[j];
            end
        end
    end

    assign m_decerr = rd_err_q;

endmodule

// File: tb/tb_bus_rr.sv
// Directed bench for bus_rr: reset, hold limit, rotation, decode, read return and async reset.
module tb_bus_rr;

    logic         clk;
    logic         reset_n;
    logic [3:0]   m_req;
    logic [3:0]   m_wr;
    logic [31:0]  m_address;
    logic [127:0] m_dout;
    logic [127:0] s_dout;

    logic [3:0]   m_grant, nh_grant;
    logic [31:0]  m_din, nh_din;
    logic         m_decerr, nh_decerr;
    logic [3:0]   s_sel, nh_sel;
    logic [7:0]   s_address, nh_address;
    logic         s_wr, nh_wr;
    logic [31:0]  s_din, nh_s_din;

    int checks   = 0;
    int failures = 0;

    bus_rr dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_address(m_address),
        .m_dout   (m_dout),
        .s_dout   (s_dout),
        .m_grant  (m_grant),
        .m_din    (m_din),
        .m_decerr (m_decerr),
        .s_sel    (s_sel),
        .s_address(s_address),
        .s_wr     (s_wr),
        .s_din    (s_din)
    );

    bus_rr #(
        .MAX_HOLD(0)
    ) dut_nh (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_address(m_address),
        .m_dout   (m_dout),
        .s_dout   (s_dout),
        .m_grant  (nh_grant),
        .m_din    (nh_din),
        .m_decerr (nh_decerr),
        .s_sel    (nh_sel),
        .s_address(nh_address),
        .s_wr     (nh_wr),
        .s_din    (nh_s_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        reset_n   = 1'b0;
        m_req     = 4'b1111;
        m_wr      = 4'b0000;
        m_address = 32'h0;
        m_dout    = '0;
        s_dout    = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};

        next_cycle();
        next_cycle();
        check("rst_grant", 32'(m_grant), 32'h1);
        check("rst_decerr", 32'(m_decerr), 32'h0);
        check("rst_sel", 32'(s_sel), 32'h1);
        check("rst_din", m_din, 32'h11111111);
        check("rst_nh_grant", 32'(nh_grant), 32'h1);

        // Release at a falling edge; every master requests continuously.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            exp_g = 4'b0001 << (i / 4);
            check($sformatf("hold_%0d", i), 32'(m_grant), 32'(exp_g));
            check($sformatf("nohold_%0d", i), 32'(nh_grant), 32'h1);
            next_cycle();
        end
        check("hold_wrap", 32'(m_grant), 32'h1);

        m_req = 4'b0110;
        next_cycle();
        check("rot_0110", 32'(m_grant), 32'b0010);
        m_req = 4'b0100;
        next_cycle();
        check("rot_0100", 32'(m_grant), 32'b0100);
        m_req = 4'b0000;
        next_cycle();
        check("park_1", 32'(m_grant), 32'b0100);
        next_cycle();
        check("park_2", 32'(m_grant), 32'b0100);
        m_req = 4'b1011;
        next_cycle();
        check("rr_not_lowest", 32'(m_grant), 32'b1000);
        m_req = 4'b0001;
        next_cycle();
        check("rot_wrap0", 32'(m_grant), 32'b0001);

        m_address = {8'hE0, 8'hC0, 8'h40, 8'h20};
        m_wr      = 4'b0001;
        m_dout    = {32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D};
        #1;
        check("rd_sel", 32'(s_sel), 32'b0010);
        check("wr_addr", 32'(s_address), 32'h20);
        check("wr_strobe", 32'(s_wr), 32'h1);
        check("wr_data", s_din, 32'hCAFEF00D);
        next_cycle();
        check("rd_data", m_din, 32'hDEADBEEF);
        check("rd_decerr", 32'(m_decerr), 32'h0);

        m_address[7:0] = 8'hA0;
        #1;
        check("err_sel", 32'(s_sel), 32'h0);
        next_cycle();
        check("err_din", m_din, 32'h0);
        check("err_flag", 32'(m_decerr), 32'h1);

        m_address[7:0] = 8'h60;
        #1;
        check("s3_sel", 32'(s_sel), 32'b1000);
        next_cycle();
        check("s3_din", m_din, 32'h44444444);
        check("s3_decerr", 32'(m_decerr), 32'h0);

        m_address[7:0] = 8'h00;
        next_cycle();
        check("s0_din", m_din, 32'h11111111);
        check("s0_decerr", 32'(m_decerr), 32'h0);

        m_req = 4'b0100;
        next_cycle();
        check("own2_grant", 32'(m_grant), 32'b0100);
        check("own2_addr", 32'(s_address), 32'hC0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_grant", 32'(m_grant), 32'b0001);
        check("async_addr", 32'(s_address), 32'h00);
        check("async_decerr", 32'(m_decerr), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
